// File: rtl/register_32_to_32.sv
// register_32_to_32: load-enabled register built one bit at a time.
// Each bit is a 2:1 feedback mux (hold vs. new data) in front of a D flip-flop
// with a synchronous active-low reset. There is no clock gating; "hold" means
// the flop recaptures its own output.
//
// Optional build macro: REG_BYTE_WRITE_EN
//   When defined, a BYTE_SEL input (one bit per 8-bit lane, last lane may be
//   partial) qualifies ENABLE so that only selected lanes load. Reset still
//   clears every lane. When undefined, all bits load together under ENABLE.

// Single-bit 2:1 multiplexer: sel=1 passes b, sel=0 passes a.
module mux2to1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// Single-bit D flip-flop, rising edge, synchronous active-low reset.
module D_FF #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    // Reset wins over data; reset is only seen at a clock edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= RESET_BIT;
        end else begin
            q <= d;
        end
    end

endmodule

// Top level: WIDTH independent mux + flop slices.
module register_32_to_32 #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [WIDTH-1:0]           IN,
    input  logic                       ENABLE,
`ifdef REG_BYTE_WRITE_EN
    input  logic [((WIDTH+7)/8)-1:0]   BYTE_SEL,
`endif
    output logic [WIDTH-1:0]           OUT
);

    // Per-bit load select and mux result feeding each flop.
    logic [WIDTH-1:0] load_sel;
    logic [WIDTH-1:0] next_bit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit

`ifdef REG_BYTE_WRITE_EN
        // Bit i belongs to byte lane i/8; the lane must be selected to load.
        assign load_sel[i] = ENABLE & BYTE_SEL[i/8];
`else
        // Whole word loads together.
        assign load_sel[i] = ENABLE;
`endif

        // Feedback mux: keep current value unless this bit is being loaded.
        mux2to1 u_mux (
            .a   (OUT[i]),
            .b   (IN[i]),
            .sel (load_sel[i]),
            .y   (next_bit[i])
        );

        // Storage flop; reset value comes from the matching RESET_VALUE bit.
        D_FF #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_ff (
            .clk     (CLK),
            .reset_n (RESET_N),
            .d       (next_bit[i]),
            .q       (OUT[i])
        );
    end

endmodule

// File: tb/tb_register_32_to_32.sv
// Testbench for register_32_to_32: vector table plus hand-written sequences,
// results checked through an expected-value queue and a small reference model.
`timescale 1ns/1ps

module tb_register_32_to_32;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        ENABLE;
    logic [31:0] IN;
    logic [31:0] OUT;
    logic [3:0]  BYTE_SEL;

    always #5 CLK = ~CLK;

    register_32_to_32 #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .IN       (IN),
        .ENABLE   (ENABLE),
`ifdef REG_BYTE_WRITE_EN
        .BYTE_SEL (BYTE_SEL),
`endif
        .OUT      (OUT)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] exp_q [$];
    logic [31:0] model;
    bit          model_known = 1'b0;
    int          vectors     = 0;
    int          miscompares = 0;

    // Reference next-state: reset, else per-lane load when enabled, else hold.
    function automatic logic [31:0] next_val(input logic [31:0] cur, input logic r,
                                             input logic e, input logic [3:0] bs,
                                             input logic [31:0] d);
        logic [31:0] n;
        n = cur;
        if (!r) return 32'h0000_0000;
        if (e) begin
            for (int k = 0; k < 4; k++) begin
`ifdef REG_BYTE_WRITE_EN
                if (bs[k]) n[8*k +: 8] = d[8*k +: 8];
`else
                if (bs[k] || !bs[k]) n[8*k +: 8] = d[8*k +: 8];
`endif
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: OUT=%h expected %h", name, act, exp);
        end
    endtask

    // Drive one edge's worth of stimulus; confirm OUT has not moved before the
    // edge, then compare against the queued expectation after it.
    task automatic apply(input logic r, input logic e, input logic [31:0] d,
                         input logic [3:0] bs, input logic [31:0] exp, input string name);
        @(negedge CLK);
        RESET_N  = r;
        ENABLE   = e;
        IN       = d;
        BYTE_SEL = bs;
        #1;
        if (model_known) check({name, "_pre"}, OUT, model);
        exp_q.push_back(exp);
        @(posedge CLK);
        #1;
        check(name, OUT, exp_q.pop_front());
        model       = exp;
        model_known = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e;
        RESET_N  = 1'b0;
        ENABLE   = 1'b0;
        IN       = 32'h0;
        BYTE_SEL = 4'hF;
        model    = 32'h0;

        //          rst_n  en    din            expected OUT
        tbl[0] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000}; // reset beats enable
        tbl[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF}; // first load after reset
        tbl[2] = '{1'b1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF}; // hold
        tbl[3] = '{1'b1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF}; // hold
        tbl[4] = '{1'b1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF}; // hold
        tbl[5] = '{1'b0, 1'b1, 32'h1111_1111, 32'h0000_0000}; // reset priority
        tbl[6] = '{1'b1, 1'b1, 32'h1111_1111, 32'h1111_1111}; // load on release edge
        tbl[7] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF}; // all ones
        tbl[8] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000}; // reset without enable

        for (int i = 0; i < 5; i++)
            apply(tbl[i].rst_n, tbl[i].en, tbl[i].din, 4'hF, tbl[i].exp, $sformatf("vec%0d", i));

        // Glitching IN between edges must not reach OUT; only the edge value counts.
        @(negedge CLK);
        ENABLE = 1'b1;
        IN     = 32'h0000_0000;
        #1 check("glitch_a", OUT, 32'hDEAD_BEEF);
        IN = 32'hA5A5_A5A5;
        #1 check("glitch_b", OUT, 32'hDEAD_BEEF);
        IN = 32'hCAFE_F00D;
        #1 check("glitch_c", OUT, 32'hDEAD_BEEF);
        exp_q.push_back(32'hCAFE_F00D);
        @(posedge CLK);
        #1 check("glitch_edge", OUT, exp_q.pop_front());
        model = 32'hCAFE_F00D;
        #2 check("glitch_stable", OUT, 32'hCAFE_F00D);

        for (int i = 5; i < 9; i++)
            apply(tbl[i].rst_n, tbl[i].en, tbl[i].din, 4'hF, tbl[i].exp, $sformatf("vec%0d", i));

        // Sweep {IN, ENABLE} through 0..127: OUT tracks the last enabled IN.
        for (int c = 0; c < 128; c++) begin
            logic [31:0] d;
            logic        en;
            d  = 32'(c >> 1);
            en = c[0];
            e  = next_val(model, 1'b1, en, 4'hF, d);
            apply(1'b1, en, d, 4'hF, e, $sformatf("sweep%0d", c));
        end

`ifdef REG_BYTE_WRITE_EN
        // Lane-selective writes, then reset must clear all lanes.
        apply(1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, "bw_reset");
        apply(1'b1, 1'b1, 32'hAABB_CCDD, 4'b0101, 32'h00BB_00DD, "bw_0101");
        apply(1'b1, 1'b1, 32'h1122_3344, 4'b1010, 32'h11BB_33DD, "bw_1010");
        apply(1'b1, 1'b1, 32'h5566_7788, 4'b0000, 32'h11BB_33DD, "bw_none");
        apply(1'b1, 1'b0, 32'h5566_7788, 4'b1111, 32'h11BB_33DD, "bw_noen");
        apply(1'b0, 1'b1, 32'h5566_7788, 4'b0001, 32'h0000_0000, "bw_reset2");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
